mem_bus: RTL and testbench
==========================

MEM_BUS -- requirements
Module: mem_bus

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, word-addressed RAM depth (byte range 0x0000..RAM_WORDS*4-1).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 104, clk cycles per UART bit.
REQ-003 SHALL have port clk  input  1  rising-edge clock, single domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rd_en  input  1  CPU read request, sampled each posedge.
REQ-006 SHALL have port wr_en  input  1  CPU write request, sampled each posedge.
REQ-007 SHALL have port addr  input  16  CPU byte address; addr[1:0] ignored.
REQ-008 SHALL have port wr_data  input  32  CPU write data.
REQ-009 SHALL have port rd_data  output  32  read response data.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse per accepted read.
REQ-011 SHALL have port uart_tx  output  1  UART 8N1 serial out, idle high.
REQ-012 SHALL have port led  output  8  LED register.

Function
REQ-013 Address map SHALL be: RAM 0x0000..RAM_WORDS*4-1; 0xFF00 UART_DATA (W); 0xFF04 UART_STATUS (R, bit0=busy, others 0); 0xFF08 LED (R/W, bits[7:0]); 0xFF0C CYCLES (R); all else unmapped.
REQ-014 Read latency SHALL be exactly one cycle: rd_en=1 at edge N -> rd_valid=1 and rd_data valid during cycle N+1 only.
REQ-015 Back-to-back reads (rd_en high on consecutive edges, addr changing) SHALL each produce rd_valid on the following cycle, no bubbles.
REQ-016 rd_valid SHALL be 0 in any cycle not following an accepted read; rd_data SHALL hold last value when rd_valid=0.
REQ-017 Writes SHALL complete at the sampling edge; no acknowledge; RAM word addr[15:2] fully overwritten.
REQ-018 rd_en and wr_en both 1: write SHALL be performed, read dropped (no rd_valid next cycle).
REQ-019 Unmapped read SHALL return rd_data=0xDEADBEEF with rd_valid; unmapped write SHALL be ignored.
REQ-020 Write to RAM then read of same address on next edge SHALL return the new data.
REQ-021 CYCLES SHALL be a 32-bit free-running counter, +1 every clk, wrapping 0xFFFFFFFF->0; read returns value at sampling edge.
REQ-022 UART FSM states SHALL be IDLE, START, DATA, STOP; each non-IDLE state bit lasts CLKS_PER_BIT cycles.
REQ-023 Write to UART_DATA in IDLE SHALL latch wr_data[7:0] and enter START next cycle; uart_tx=0 in START, LSB-first data in DATA (8 bits), 1 in STOP, then IDLE.
REQ-024 Write to UART_DATA while busy (state != IDLE) SHALL be dropped silently, in-flight byte unaffected.
REQ-025 busy SHALL be 1 from the cycle after an accepted UART_DATA write through the last STOP cycle.
REQ-026 Bit-timing counter and bit index SHALL be sized by clog2 of their ranges and reset to 0 on every state change.

Reset
REQ-027 rst_n=0 SHALL immediately force rd_valid=0, rd_data=0, led=0, CYCLES=0, UART state IDLE, uart_tx=1, counters 0.
REQ-028 Reset mid-transmission SHALL abort the byte; uart_tx high within the reset cycle.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Requests SHALL be accepted from the first posedge after rst_n deasserts.

Verification
REQ-031 Write 0x12345678 to 0x0010, read 0x0010 next edge -> rd_valid one cycle later, rd_data=0x12345678.
REQ-032 Reads of 0x0000,0x0004,0x0008 on three consecutive edges -> three consecutive rd_valid pulses with matching data.
REQ-033 Write 0x41 to 0xFF00 (CLKS_PER_BIT=4) -> uart_tx 0 for 4 cycles, bits 1,0,0,0,0,0,1,0 each 4 cycles, 1 for 4 cycles; UART_STATUS=1 during, 0 after; second write mid-frame ignored.
REQ-034 Read 0x8000 (unmapped) -> rd_data=0xDEADBEEF; simultaneous rd_en+wr_en to 0xFF08 with 0xA5 -> led=0xA5, no rd_valid.
REQ-035 Assert rst_n=0 during DATA state with led=0xA5 -> uart_tx=1, led=0, CYCLES=0; RAM word 0x0010 still 0x12345678.

Source files
------------

// File: rtl/mem_bus.sv
// rtl/mem_bus.sv - CPU memory bus: word RAM, UART 8N1 transmitter, LED register and cycle counter.
// Single-cycle registered reads; writes complete at the sampling edge.
module mem_bus #(
  parameter int RAM_WORDS    = 4096,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        uart_tx,
  output logic [7:0]  led
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [15:0] A_UART_DATA   = 16'hFF00;
  localparam logic [15:0] A_UART_STATUS = 16'hFF04;
  localparam logic [15:0] A_LED         = 16'hFF08;
  localparam logic [15:0] A_CYCLES      = 16'hFF0C;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_rd_data;
  logic          r_rd_valid;
  logic [31:0]   r_cycles;
  logic [7:0]    r_led;

  uart_state_t   r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_tx_byte;

  uart_state_t   w_state_nxt;
  logic [CW-1:0] w_bit_cnt_nxt;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    w_tx_byte_nxt;

  logic [15:0]   w_addr;
  logic          w_ram_hit;
  logic [AW-1:0] w_ram_idx;
  logic          w_rd_acc;
  logic          w_busy;
  logic          w_uart_wr;
  logic [31:0]   w_rd_mux;
  logic          w_tx;

  assign w_addr    = addr & 16'hFFFC;
  assign w_ram_hit = {16'd0, w_addr} < 32'(RAM_WORDS * 4);
  assign w_ram_idx = w_addr[AW+1:2];
  // A simultaneous write wins; the read is dropped entirely.
  assign w_rd_acc  = rd_en & ~wr_en;
  assign w_busy    = (r_state != S_IDLE);
  assign w_uart_wr = wr_en && (w_addr == A_UART_DATA);

  // RAM has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && w_ram_hit) begin
      r_ram[w_ram_idx] <= wr_data;
    end
  end

  always_comb begin
    w_rd_mux = 32'hDEADBEEF;
    if (w_ram_hit) begin
      w_rd_mux = r_ram[w_ram_idx];
    end else begin
      case (w_addr)
        A_UART_DATA:   w_rd_mux = 32'd0;
        A_UART_STATUS: w_rd_mux = {31'd0, w_busy};
        A_LED:         w_rd_mux = {24'd0, r_led};
        A_CYCLES:      w_rd_mux = r_cycles;
        default:       w_rd_mux = 32'hDEADBEEF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 32'd0;
      r_cycles   <= 32'd0;
      r_led      <= 8'd0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_cycles   <= r_cycles + 32'd1;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_mux;
      end
      if (wr_en && (w_addr == A_LED)) begin
        r_led <= wr_data[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_tx_byte <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx_byte <= w_tx_byte_nxt;
    end
  end

  // Bit counter and index both restart from zero on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_byte_nxt = r_tx_byte;
    case (r_state)
      S_IDLE: begin
        w_bit_cnt_nxt = '0;
        w_bit_idx_nxt = 3'd0;
        if (w_uart_wr) begin
          w_state_nxt   = S_START;
          w_tx_byte_nxt = wr_data[7:0];
        end
      end
      S_START: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_bit_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = S_STOP;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
        w_bit_idx_nxt = 3'd0;
      end
    endcase
  end

  // Line level decodes straight from state so reset returns it high at once.
  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = r_tx_byte[r_bit_idx];
      default: w_tx = 1'b1;
    endcase
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign uart_tx  = w_tx;
  assign led      = r_led;

endmodule

// File: tb/tb_mem_bus.sv
// tb/tb_mem_bus.sv - Self-checking bench for mem_bus against a cycle-indexed reference model.
module tb_mem_bus;

  localparam int RW    = 256;
  localparam int CPB   = 4;
  localparam int FRAME = CPB * 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        uart_tx;
  logic [7:0]  led;

  mem_bus #(.RAM_WORDS(RW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .uart_tx(uart_tx), .led(led)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_ram [RW];
  logic [7:0]  m_led = 8'd0;
  logic [7:0]  m_byte = 8'd0;
  logic [31:0] m_last = 32'd0;
  int          n = 0;
  int          e_start = -1000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Frame accepted at edge e occupies the 40 cycles after it.
  function automatic bit m_busy(input int k);
    return (k >= e_start + 1) && (k <= e_start + FRAME);
  endfunction

  function automatic logic m_tx(input int m);
    int t;
    t = m - e_start;
    if (t < 0 || t >= FRAME) return 1'b1;
    if (t < CPB) return 1'b0;
    if (t < 9 * CPB) return m_byte[(t - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    int aa;
    aa = int'(a) & 32'hFFFC;
    if (aa < RW * 4) return m_ram[aa >> 2];
    case (aa)
      32'hFF00: return 32'd0;
      32'hFF04: return {31'd0, m_busy(n)};
      32'hFF08: return {24'd0, m_led};
      32'hFF0C: return n;
      default:  return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic step(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d);
    bit          ev;
    logic [31:0] ed;
    int          aa;
    rd_en = rd; wr_en = wr; addr = a; wr_data = d;
    ev = rd && !wr;
    ed = m_read(a);
    if (wr) begin
      aa = int'(a) & 32'hFFFC;
      if (aa < RW * 4) m_ram[aa >> 2] = d;
      else if (aa == 32'hFF08) m_led = d[7:0];
      else if (aa == 32'hFF00 && !m_busy(n)) begin
        e_start = n;
        m_byte = d[7:0];
      end
    end
    @(posedge clk);
    n++;
    @(negedge clk);
    check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, ev});
    if (ev) m_last = ed;
    check_eq(ev ? "rd_data" : "rd_hold", rd_data, m_last);
    check_eq("led", {24'd0, led}, {24'd0, m_led});
    check_eq("uart_tx", {31'd0, uart_tx}, {31'd0, m_tx(n - 1)});
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    check_eq("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("rst_led", {24'd0, led}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    m_led = 8'd0; m_last = 32'd0; e_start = -1000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2: return 16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      3:       return 16'hFF00;
      4:       return 16'hFF04 | 16'($urandom_range(0, 3));
      5:       return 16'hFF08;
      6:       return 16'hFF0C;
      default: return 16'h0400 + 16'($urandom_range(0, 16'h7000));
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check_eq("init_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("init_rd_data", rd_data, 32'd0);
    check_eq("init_led", {24'd0, led}, 32'd0);
    check_eq("init_uart_tx", {31'd0, uart_tx}, 32'd1);
    rst_n = 1'b1;
    n = 0;

    step(1, 0, 16'hFF0C, 32'd0);
    for (int i = 0; i < 64; i++) step(0, 1, 16'(i * 4), $urandom);

    step(0, 1, 16'h0010, 32'h12345678);
    step(1, 0, 16'h0010, 32'd0);
    step(0, 0, 16'h0000, 32'd0);

    step(1, 0, 16'h0000, 32'd0);
    step(1, 0, 16'h0004, 32'd0);
    step(1, 0, 16'h0008, 32'd0);
    step(0, 0, 16'h0000, 32'd0);

    step(0, 1, 16'hFF00, 32'h41);
    for (int i = 0; i < FRAME + 4; i++) begin
      if (i == 10) step(0, 1, 16'hFF00, 32'h55);
      else step(1, 0, 16'hFF04, 32'd0);
    end

    step(1, 0, 16'h8000, 32'd0);
    step(1, 1, 16'hFF08, 32'hA5);
    step(1, 0, 16'hFF08, 32'd0);

    step(0, 1, 16'hFF00, 32'hC3);
    for (int i = 0; i < 12; i++) step(0, 0, 16'h0000, 32'd0);
    async_reset();
    step(1, 0, 16'hFF0C, 32'd0);
    step(1, 0, 16'h0010, 32'd0);
    step(1, 0, 16'hFF08, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rand_addr(), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
